// File: rtl/data_memory_controller_if.sv
// DCache-side request/response and 8-bit memory bus signals of the data memory controller.
// The master modport is the controller; the slave modport is its environment.
interface data_memory_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [1:0]            accessType;
    logic                  readWriteIn;
    logic [ADDR_WIDTH-1:0] dataAddr;
    logic [31:0]           dataIn;
    logic                  dataValid;
    logic [31:0]           dataOut;
    logic                  dataWriteSuc;
    logic                  memReq;
    logic                  memGrant;
    logic [7:0]            memIn;
    logic [7:0]            memOut;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  memWrite;
    logic                  ioBufferFull;

    modport master (
        input  accessType, readWriteIn, dataAddr, dataIn, memGrant, memIn, ioBufferFull,
        output dataValid, dataOut, dataWriteSuc, memReq, memOut, memAddr, memWrite
    );

    modport slave (
        output accessType, readWriteIn, dataAddr, dataIn, memGrant, memIn, ioBufferFull,
        input  dataValid, dataOut, dataWriteSuc, memReq, memOut, memAddr, memWrite
    );
endinterface

// File: rtl/data_memory_controller.sv
// Byte-serial data memory controller: splits byte/half/word requests into little-endian
// byte transfers on a shared 8-bit bus, holding I/O stores while the I/O buffer is full.
module data_memory_controller #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned IO_SEL_HI  = 17
) (
    input logic                      clockIn,
    input logic                      resetIn,
    data_memory_controller_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitGrant,
        StXfer
    } state_e;

    state_e                stateQ, stateD;
    logic                  opReadQ, opReadD;
    logic                  isIoQ, isIoD;
    logic [2:0]            sizeQ, sizeD;
    logic [2:0]            kQ, kD;
    logic [ADDR_WIDTH-1:0] baseQ, baseD;
    logic [31:0]           wrDataQ, wrDataD;
    logic                  rdAddrActiveQ, rdAddrActiveD;
    logic                  capValidQ, capValidD;
    logic [1:0]            capIdxQ, capIdxD;
    logic [31:0]           rdBufQ, rdBufD;

    logic                  dataValidQ, dataValidD;
    logic [31:0]           dataOutQ, dataOutD;
    logic                  dataWriteSucQ, dataWriteSucD;
    logic                  memReqQ, memReqD;
    logic [7:0]            memOutQ, memOutD;
    logic [ADDR_WIDTH-1:0] memAddrQ, memAddrD;
    logic                  memWriteQ, memWriteD;

    logic                  ioHold;

    assign ioHold = isIoQ && !opReadQ && bus.ioBufferFull;

    always_comb begin
        stateD        = stateQ;
        opReadD       = opReadQ;
        isIoD         = isIoQ;
        sizeD         = sizeQ;
        kD            = kQ;
        baseD         = baseQ;
        wrDataD       = wrDataQ;
        rdBufD        = rdBufQ;
        rdAddrActiveD = 1'b0;
        // memIn answers the address driven last cycle, whose index is kQ-1
        capValidD     = rdAddrActiveQ;
        capIdxD       = kQ[1:0] - 2'd1;
        dataValidD    = 1'b0;
        dataOutD      = dataOutQ;
        dataWriteSucD = 1'b0;
        memReqD       = memReqQ;
        memOutD       = memOutQ;
        memAddrD      = memAddrQ;
        memWriteD     = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (bus.accessType != 2'b00) begin
                    opReadD = bus.readWriteIn;
                    isIoD   = (bus.dataAddr[IO_SEL_HI -: 2] == 2'b11);
                    case (bus.accessType)
                        2'b01:   sizeD = 3'd1;
                        2'b10:   sizeD = 3'd2;
                        default: sizeD = 3'd4;
                    endcase
                    baseD   = bus.dataAddr;
                    wrDataD = bus.dataIn;
                    kD      = 3'd0;
                    rdBufD  = '0;
                    memReqD = 1'b1;
                    stateD  = StWaitGrant;
                end
            end
            StWaitGrant, StXfer: begin
                if (stateQ == StXfer || bus.memGrant) begin
                    stateD = StXfer;
                    if (kQ != sizeQ) begin
                        if (!ioHold) begin
                            memAddrD      = baseQ + ADDR_WIDTH'(kQ);
                            memOutD       = wrDataQ[{kQ[1:0], 3'b000} +: 8];
                            memWriteD     = !opReadQ;
                            rdAddrActiveD = opReadQ;
                            kD            = kQ + 3'd1;
                        end
                    end else if (!opReadQ) begin
                        dataWriteSucD = 1'b1;
                        memReqD       = 1'b0;
                        stateD        = StIdle;
                    end
                end
            end
            default: stateD = StIdle;
        endcase

        // Reads finish once the byte for the last address has been captured.
        if (capValidQ) begin
            rdBufD[{capIdxQ, 3'b000} +: 8] = bus.memIn;
            if ({1'b0, capIdxQ} == sizeQ - 3'd1) begin
                dataValidD = 1'b1;
                dataOutD   = rdBufD;
                memReqD    = 1'b0;
                stateD     = StIdle;
            end
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            stateQ        <= StIdle;
            opReadQ       <= 1'b0;
            isIoQ         <= 1'b0;
            sizeQ         <= 3'd0;
            kQ            <= 3'd0;
            baseQ         <= '0;
            wrDataQ       <= '0;
            rdAddrActiveQ <= 1'b0;
            capValidQ     <= 1'b0;
            capIdxQ       <= 2'd0;
            rdBufQ        <= '0;
            dataValidQ    <= 1'b0;
            dataOutQ      <= '0;
            dataWriteSucQ <= 1'b0;
            memReqQ       <= 1'b0;
            memOutQ       <= '0;
            memAddrQ      <= '0;
            memWriteQ     <= 1'b0;
        end else begin
            stateQ        <= stateD;
            opReadQ       <= opReadD;
            isIoQ         <= isIoD;
            sizeQ         <= sizeD;
            kQ            <= kD;
            baseQ         <= baseD;
            wrDataQ       <= wrDataD;
            rdAddrActiveQ <= rdAddrActiveD;
            capValidQ     <= capValidD;
            capIdxQ       <= capIdxD;
            rdBufQ        <= rdBufD;
            dataValidQ    <= dataValidD;
            dataOutQ      <= dataOutD;
            dataWriteSucQ <= dataWriteSucD;
            memReqQ       <= memReqD;
            memOutQ       <= memOutD;
            memAddrQ      <= memAddrD;
            memWriteQ     <= memWriteD;
        end
    end

    assign bus.dataValid    = dataValidQ;
    assign bus.dataOut      = dataOutQ;
    assign bus.dataWriteSuc = dataWriteSucQ;
    assign bus.memReq       = memReqQ;
    assign bus.memOut       = memOutQ;
    assign bus.memAddr      = memAddrQ;
    assign bus.memWrite     = memWriteQ;

endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: directed scenarios plus randomized requests checked
// against a transaction-level model of addresses, bytes, hold cycles and completion time.
module tb_data_memory_controller;
    localparam int unsigned AW     = 32;
    localparam int          MaxCyc = 64;

    logic        clockIn  = 1'b0;
    logic        resetIn  = 1'b1;
    int          checks   = 0;
    int          errors   = 0;
    logic [31:0] lastRead = '0;

    logic [7:0]  memOverride [logic [31:0]];
    logic        obsWrite [MaxCyc];
    logic        obsReq   [MaxCyc];
    logic        obsValid [MaxCyc];
    logic        obsSuc   [MaxCyc];
    logic [31:0] obsAddr  [MaxCyc];
    logic [31:0] obsData  [MaxCyc];
    logic [7:0]  obsOut   [MaxCyc];

    always #5 clockIn = ~clockIn;

    data_memory_controller_if #(.ADDR_WIDTH(AW)) bus ();

    data_memory_controller #(
        .ADDR_WIDTH(AW),
        .IO_SEL_HI (17)
    ) dut (
        .clockIn(clockIn),
        .resetIn(resetIn),
        .bus    (bus)
    );

    function automatic logic [7:0] memByte(input logic [31:0] a);
        if (memOverride.exists(a)) return memOverride[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
    endfunction

    // Memory answers one cycle after the address is driven.
    always @(posedge clockIn) bus.memIn <= memByte(bus.memAddr);

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " flags"}, {20'd0, bus.dataValid, bus.dataWriteSuc, bus.memReq, bus.memWrite,
                                bus.memOut}, 32'd0);
        check({tag, " dataOut"}, bus.dataOut, 32'd0);
        check({tag, " memAddr"}, bus.memAddr, 32'd0);
    endtask

    // Issues one request in the current cycle (cycle 0), runs it to one cycle past completion
    // and checks it against the model. Returns the observed completion cycle (-1 if none).
    task automatic runOp(input bit rd, input int n, input logic [31:0] addr,
                         input logic [31:0] data, input int gd, input logic [31:0] ioMask,
                         output int doneCyc);
        int          issueCyc [4];
        int          t, k, expDone, pulses, writes;
        bit          io, reqOk;
        logic [31:0] expRes;

        io = (addr[17:16] == 2'b11);
        t  = 1 + gd;
        k  = 0;
        while (k < n) begin
            if (io && !rd && t < 32 && ioMask[t]) begin
                t++;
            end else begin
                issueCyc[k] = t + 1;
                k++;
                t++;
            end
        end
        expDone = rd ? t + 2 : t + 1;
        expRes  = '0;
        for (int b = 0; b < n; b++) expRes[8*b +: 8] = memByte(addr + 32'(b));

        bus.accessType   = (n == 1) ? 2'b01 : (n == 2) ? 2'b10 : 2'b11;
        bus.readWriteIn  = rd;
        bus.dataAddr     = addr;
        bus.dataIn       = data;
        bus.memGrant     = 1'b0;
        bus.ioBufferFull = ioMask[0];
        for (int c = 1; c <= expDone + 1; c++) begin
            @(posedge clockIn);
            #1;
            bus.accessType   = 2'b00;
            bus.readWriteIn  = 1'($urandom);
            bus.dataAddr     = $urandom;
            bus.dataIn       = $urandom;
            bus.memGrant     = (c >= 1 + gd) && bus.memReq;
            bus.ioBufferFull = (c < 32) ? ioMask[c] : 1'b0;
            obsWrite[c] = bus.memWrite;
            obsReq[c]   = bus.memReq;
            obsValid[c] = bus.dataValid;
            obsSuc[c]   = bus.dataWriteSuc;
            obsAddr[c]  = bus.memAddr;
            obsData[c]  = bus.dataOut;
            obsOut[c]   = bus.memOut;
        end
        bus.memGrant = 1'b0;

        doneCyc = -1;
        pulses  = 0;
        writes  = 0;
        reqOk   = 1'b1;
        for (int c = 1; c <= expDone + 1; c++) begin
            pulses += int'(obsValid[c]) + int'(obsSuc[c]);
            writes += int'(obsWrite[c]);
            if (doneCyc < 0 && (obsValid[c] || obsSuc[c])) doneCyc = c;
            if (c < expDone && obsReq[c] !== 1'b1) reqOk = 1'b0;
            if (c == expDone && obsReq[c] !== 1'b0) reqOk = 1'b0;
        end
        check("pulse count", 32'(pulses), 32'd1);
        check("completion cycle", 32'(doneCyc), 32'(expDone));
        check("dataValid at done", 32'(obsValid[expDone]), 32'(rd));
        check("dataWriteSuc at done", 32'(obsSuc[expDone]), 32'(!rd));
        check("memWrite cycles", 32'(writes), rd ? 32'd0 : 32'(n));
        check("memReq window", 32'(reqOk), 32'd1);
        for (int b = 0; b < n; b++) begin
            check("byte address", obsAddr[issueCyc[b]], addr + 32'(b));
            check("byte memWrite", 32'(obsWrite[issueCyc[b]]), 32'(!rd));
            if (!rd) check("byte memOut", 32'(obsOut[issueCyc[b]]), 32'(data[8*b +: 8]));
        end
        if (rd) lastRead = expRes;
        check("dataOut", obsData[expDone], lastRead);
    endtask

    initial begin
        int          d;
        bit          any;
        bit          rd;
        int          n, gd;
        logic [31:0] addr, mask;

        bus.accessType   = 2'b00;
        bus.readWriteIn  = 1'b0;
        bus.dataAddr     = '0;
        bus.dataIn       = '0;
        bus.memGrant     = 1'b0;
        bus.ioBufferFull = 1'b0;
        memOverride[32'h100] = 8'h11;
        memOverride[32'h101] = 8'h22;
        memOverride[32'h102] = 8'h33;
        memOverride[32'h103] = 8'h44;
        memOverride[32'h203] = 8'h80;

        #2 resetIn = 1'b0;
        repeat (3) @(posedge clockIn);
        #1;
        checkAllZero("reset");
        resetIn = 1'b1;
        @(posedge clockIn);
        #1;

        runOp(1'b1, 4, 32'h100, 32'h0, 0, 32'h0, d);
        check("word read done cycle", 32'(d), 32'd7);
        check("word read result", bus.dataOut, 32'h4433_2211);

        runOp(1'b1, 1, 32'h203, 32'h0, 0, 32'h0, d);
        check("byte read done cycle", 32'(d), 32'd4);
        check("byte read zero-extend", bus.dataOut, 32'h0000_0080);

        runOp(1'b1, 2, 32'hFFFF_FFFE, 32'h0, 0, 32'h0, d);
        check("wrap addr 0", obsAddr[2], 32'hFFFF_FFFE);
        check("wrap addr 1", obsAddr[3], 32'hFFFF_FFFF);

        runOp(1'b0, 2, 32'h1000, 32'h0000_BEEF, 0, 32'h0, d);
        check("half write done cycle", 32'(d), 32'd4);
        check("half write byte0", {obsWrite[2], obsAddr[2][15:0], obsOut[2]}, {1'b1, 16'h1000, 8'hEF});
        check("half write byte1", {obsWrite[3], obsAddr[3][15:0], obsOut[3]}, {1'b1, 16'h1001, 8'hBE});
        check("half write memReq drop", 32'(obsReq[4]), 32'd0);

        runOp(1'b0, 1, 32'h3_0000, 32'h41, 0, 32'b1110, d);
        any = obsWrite[1] | obsWrite[2] | obsWrite[3] | obsWrite[4];
        check("io hold no write", 32'(any), 32'd0);
        check("io hold write cycle", 32'(obsWrite[5]), 32'd1);
        check("io hold done cycle", 32'(d), 32'd6);
        runOp(1'b0, 1, 32'h2_0000, 32'h41, 0, 32'b1110, d);
        check("non-io done cycle", 32'(d), 32'd3);

        runOp(1'b0, 4, 32'h5000, 32'hCAFE_F00D, 5, 32'h0, d);
        check("grant delay done cycle", 32'(d), 32'd11);
        check("grant delay first write", {31'd0, obsWrite[7]}, 32'd1);

        // Reset in cycle 4 of a word read.
        bus.accessType  = 2'b11;
        bus.readWriteIn = 1'b1;
        bus.dataAddr    = 32'h400;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clockIn);
            #1;
            bus.accessType = 2'b00;
            bus.memGrant   = bus.memReq;
        end
        check("read in flight", 32'(bus.memReq), 32'd1);
        resetIn = 1'b0;
        #1;
        checkAllZero("mid-op reset");
        any = 1'b0;
        repeat (2) begin
            @(posedge clockIn);
            #1;
            any |= bus.dataValid;
        end
        resetIn      = 1'b1;
        bus.memGrant = 1'b0;
        repeat (6) begin
            @(posedge clockIn);
            #1;
            any |= bus.dataValid | bus.memReq;
        end
        check("no activity after reset", 32'(any), 32'd0);
        lastRead = '0;
        runOp(1'b1, 1, 32'h204, 32'h0, 0, 32'h0, d);
        check("read after reset done cycle", 32'(d), 32'd4);

        for (int i = 0; i < 24; i++) begin
            rd   = 1'($urandom);
            n    = 1 << $urandom_range(0, 2);
            gd   = $urandom_range(0, 3);
            mask = $urandom & 32'h0000_FFFE;
            addr = $urandom;
            case ($urandom_range(0, 3))
                0: addr[17:16] = 2'b11;
                1: addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                2: addr[17:16] = 2'b10;
                default: ;
            endcase
            runOp(rd, n, addr, $urandom, gd, mask, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

Byte-serial memory controller directly downstream of the load/store buffer. It accepts one byte, half-word or word request on the DCache-side interface, requests the shared 8-bit memory bus from the bus arbiter, and splits the request into little-endian byte transfers. For loads it returns the zero-extended result; for stores it reports completion. It also holds I/O stores while the I/O buffer is full.

## Interface
- ADDR_WIDTH, 32, width of request and memory addresses.
- IO_SEL_HI, 17, upper bit of the I/O region selector. An address is I/O when bits [IO_SEL_HI:IO_SEL_HI-1] equal 2'b11.

Ports:
- clockIn  in  1  clock. One clock only; everything is on the rising edge.
- resetIn  in  1  reset, asynchronous and active-low.
- accessType  in  2  request size: 00 none, 01 byte, 10 half-word, 11 word.
- readWriteIn  in  1  1 = read, 0 = write.
- dataAddr  in  ADDR_WIDTH  request byte address.
- dataIn  in  32  store data. Low bytes are used.
- dataValid  out  1  one-cycle pulse; read result is on dataOut.
- dataOut  out  32  read result, zero-extended.
- dataWriteSuc  out  1  one-cycle pulse when a store completes.
- memReq  out  1  bus request to the arbiter.
- memGrant  in  1  bus grant from the arbiter.
- memIn  in  8  read byte. Valid one cycle after its address was driven.
- memOut  out  8  write byte.
- memAddr  out  ADDR_WIDTH  byte address.
- memWrite  out  1  1 = write this cycle.
- ioBufferFull  in  1  I/O output buffer full.

## Operation
- States: IDLE, WAIT_GRANT, XFER.
  - IDLE → WAIT_GRANT when accessType != 00. On that edge, latch op, size N (1/2/4), address, data and I/O flag.
  - WAIT_GRANT → XFER on the first edge with memGrant=1. The counter k is cleared.
  - XFER → IDLE after the last transfer cycle. The completion pulse follows.
- Requests seen outside IDLE are ignored. The upstream block guarantees it sends only one request at a time.
- A request may be accepted in the same cycle as a completion pulse, because that cycle is already IDLE.
- Addressing: byte k uses address base+k, modulo 2^ADDR_WIDTH (it wraps). No alignment is required.
- Write: byte k = dataIn[8k+7:8k], with memWrite=1, for k=0..N-1.
- I/O write hold:
  - If the I/O flag is set and ioBufferFull=1 at the edge that would issue the next byte, issue nothing.
  - During the hold, drive memWrite=0 and keep k unchanged. Retry each edge.
  - Non-I/O writes ignore ioBufferFull.
- Read:
  - Drive addresses for k=0..N-1 with memWrite=0.
  - Capture memIn as byte k one cycle later.
  - Result = {zeros, byte N-1 … byte 0}.
  - Sign extension is not done here.
- memReq: 1 in WAIT_GRANT and XFER, 0 otherwise.
- The arbiter keeps memGrant high until memReq drops. If memGrant falls during XFER, that is an arbiter fault; it is not handled.
- memOut and memAddr are don't-care when memWrite=0 outside the read address cycles.

## Timing
- All outputs are registered. Reset value of every output is 0, and state is IDLE.
- Cycle numbering: the request is present in cycle 0 and sampled at the end of cycle 0.
- Cycle 1: memReq=1. With memGrant=1 in cycle 1, transfers occupy cycles 2..N+1. Each cycle of grant delay shifts everything later by one cycle.
- Write: dataWriteSuc=1 in cycle N+2.
  - Word write completes in cycle 6; half-word in cycle 4.
  - Each I/O hold cycle adds one cycle.
- Read: the last byte is captured at the end of cycle N+2, and dataValid=1 with dataOut in cycle N+3.
  - Word read completes in cycle 7; byte read in cycle 4.
  - dataOut holds its value until the next read completes.
- memReq drops in the completion-pulse cycle.
- The pulses last exactly one cycle. dataValid and dataWriteSuc are never high together.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronous) and the state returns to IDLE. The in-flight request is dropped and no pulse is produced. The first request accepted after reset release behaves normally.

## Test plan
- Word read, address 0x100, memory bytes 0x11, 0x22, 0x33, 0x44, immediate grant → memAddr 0x100–0x103 in cycles 2–5; dataValid=1 with dataOut=0x44332211 in cycle 7 only.
- Byte read of 0x80 at 0x203 → dataOut=0x00000080 (no sign extension) in cycle 4. Half-word read at 0xFFFFFFFE → addresses 0xFFFFFFFE then 0xFFFFFFFF (wraps).
- Half-word write of 0x0000BEEF to 0x1000 → cycle 2: memOut 0xEF at 0x1000 with memWrite=1; cycle 3: memOut 0xBE at 0x1001; dataWriteSuc=1 in cycle 4; memReq=0 in cycle 4.
- Byte write of 0x41 to 0x30000, ioBufferFull=1 for cycles 1–3 → memWrite=0 through cycle 4; write issued in cycle 5; dataWriteSuc in cycle 6. The same store to 0x20000 is unaffected (completes in cycle 3).
- memGrant withheld for 5 cycles on a word write → memReq held high; first memWrite appears the cycle after grant is seen; completion is shifted by exactly 5 cycles.
- Reset asserted in cycle 4 of a word read → all outputs 0 at once and no dataValid. A new byte read after release completes in cycle 4 of that request.
